// File: rtl/oin_request_m2p.sv
// Method-to-pipe serializer: packs say/say2 calls into tagged 144-bit words,
// buffers them in a DEPTH-entry FIFO and offers them to a downstream pipe.
module oin_request_m2p #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] TAG_SAY  = 16'd0,
  parameter logic [15:0] TAG_SAY2 = 16'd1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          say__ena,
  input  logic [31:0]   say_v,
  output logic          say__rdy,
  input  logic          say2__ena,
  input  logic [31:0]   say2_a,
  input  logic [31:0]   say2_b,
  output logic          say2__rdy,
  output logic          enq__ena,
  output logic [143:0]  enq_v,
  input  logic          enq__rdy,
  output logic [15:0]   sent_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [143:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [15:0]   sent_count_reg;

  logic          not_full;
  logic          not_empty;
  logic          say_fire;
  logic          say2_fire;
  logic          push;
  logic          pop;
  logic [143:0]  wdata;

  assign not_full  = (count_reg != FULL);
  assign not_empty = (count_reg != '0);

  // Ready is gated by the registered count only, never by downstream ready.
  assign say__rdy  = not_full;
  assign say2__rdy = not_full && !say__ena;

  assign say_fire  = say__ena && say__rdy;
  assign say2_fire = say2__ena && say2__rdy;
  assign push      = say_fire || say2_fire;
  assign pop       = not_empty && enq__rdy;

  assign wdata = say_fire ? {TAG_SAY,  16'h0, say_v,  32'h0,  48'h0}
                          : {TAG_SAY2, 16'h0, say2_a, say2_b, 48'h0};

  assign enq__ena   = not_empty;
  assign enq_v      = not_empty ? mem[rd_ptr_reg] : 144'h0;
  assign sent_count = sent_count_reg;

  // Storage carries no reset; an empty FIFO masks whatever it holds.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      sent_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg     <= rd_ptr_reg + AW'(1);
        sent_count_reg <= sent_count_reg + 16'd1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: doc/oin_request_m2p.md
# oin_request_m2p

Method-to-pipe serializer for the OinRequest indication path. It accepts `say` and `say2` method calls and packs each into a 144-bit tagged pipe word. The words are buffered in a small FIFO and presented to a downstream PipeIn server. It sits at the transmit end of the link, and its packing is the exact inverse of the pipe-to-method demux on the receive end.

## Interface
Parameters:
- DEPTH, 2, FIFO entries; power of two, ≥2
- TAG_SAY, 16'd0, tag for `say` packets
- TAG_SAY2, 16'd1, tag for `say2` packets

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- method.say__ENA  in  1  `say` call strobe
- method.say$v  in  32  `say` argument
- method.say__RDY  out  1  `say` may fire
- method.say2__ENA  in  1  `say2` call strobe
- method.say2$a  in  32  `say2` first argument
- method.say2$b  in  32  `say2` second argument
- method.say2__RDY  out  1  `say2` may fire
- pipe.enq__ENA  out  1  packet valid toward downstream
- pipe.enq$v  out  144  packet
- pipe.enq__RDY  in  1  downstream accepts packet
- sent_count  out  16  packets accepted by downstream, wraps

## Operation
- Packet layout:
  - [143:128] tag
  - [127:112] zero
  - [111:80] arg0
  - [79:48] arg1
  - [47:0] zero
- `say` packs as: tag=TAG_SAY, arg0=say$v, arg1=0.
- `say2` packs as: tag=TAG_SAY2, arg0=say2$a, arg1=say2$b.
- FIFO state: DEPTH×144 storage, wr_ptr, rd_ptr, and a count register of width log2(DEPTH)+1.
- Ready rules:
  - say__RDY = (count != DEPTH).
  - say2__RDY = (count != DEPTH) && !say__ENA.
  - At most one method fires per cycle, and `say` has priority.
  - Neither RDY depends on pipe.enq__RDY.
- Push: a method ENA while its RDY is high writes the packed word at wr_ptr, and wr_ptr advances modulo DEPTH.
- ENA while RDY is low is a caller protocol violation. It is ignored, with no push and no state change.
- Pipe output:
  - pipe.enq__ENA = (count != 0).
  - pipe.enq$v = mem[rd_ptr], and is all zeros when empty.
- Pop: occurs when pipe.enq__ENA && pipe.enq__RDY. rd_ptr advances and sent_count increments by 1, wrapping 16'hFFFF→0.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Count update: push only → +1; pop only → −1.
- Full: RDY is gated by the registered count, so a push is refused even when a pop happens in the same cycle. The freed slot becomes available the next cycle.

## Timing
- Reset (nRST low, asynchronous): count, wr_ptr, rd_ptr and sent_count clear to 0. Storage is not reset.
- Outputs during reset: pipe.enq__ENA=0, pipe.enq$v=0, say__RDY=1, say2__RDY=1 unless say__ENA is high.
- Reset asserted mid-operation: all buffered packets are discarded and no partial packet is ever emitted.
- Latency: a method accepted at edge N is visible on pipe.enq__ENA/pipe.enq$v after edge N. It can be popped at edge N+1 at the earliest.
- Throughput: with DEPTH=2 and downstream always ready, one packet per cycle is sustained.
- Ordering: packets leave in strict acceptance order.
- Output stability: while pipe.enq__ENA=1 and enq__RDY=0, pipe.enq$v holds stable.
- Pointer wrap: DEPTH is a power of two, so pointers wrap naturally. count distinguishes full from empty.

## Test plan
1. Single `say`: after reset, say(32'hDEADBEEF) with enq__RDY=1 → next cycle enq__ENA=1, enq$v={16'h0,16'h0,32'hDEADBEEF,32'h0,48'h0}. It pops one cycle later, after which sent_count=1 and enq__ENA=0.
2. Single `say2`: say2(a=32'h1,b=32'h2) → enq$v[143:128]=16'h1, [111:80]=32'h1, [79:48]=32'h2, all other bits 0.
3. Backpressure/full: enq__RDY=0 while `say` is called with values 10, 11, 12 → values 10 and 11 are accepted, say__RDY=0 after the second push, and the third call is ignored. With enq__RDY=1 the outputs are 10 then 11 in order, and sent_count=2.
4. Priority: say__ENA and say2__ENA both high with count=0 → say2__RDY=0, only the `say` packet is enqueued, and count=1.
5. Streaming: 300 alternating say/say2 calls with enq__RDY randomly toggled → all 300 are received in order with matching payloads. sent_count=300 at the end; a separate 65537-pop run checks the wrap back to 1.
6. Reset mid-stream: FIFO holds 2 packets and nRST is pulsed low between clock edges → enq__ENA drops immediately, count and sent_count read 0, and after release no stale packet appears.
